// File: rtl/store_buf_pkg.sv
// Store buffer shared types: entry layout and word-address compare.
// Struct widths fix the ADDR_W/DATA_W defaults of the top.
package store_buf_pkg;

  localparam int SB_ADDR_W = 32;
  localparam int SB_DATA_W = 32;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;

  function automatic logic word_match(
    input logic [SB_ADDR_W-1:0] a,
    input logic [SB_ADDR_W-1:0] b
  );
    return a[SB_ADDR_W-1:2] == b[SB_ADDR_W-1:2];
  endfunction

endpackage

// File: rtl/sb_fwd_match.sv
// Youngest-hit search over buffered stores for load forwarding.
// Walks oldest to youngest from head; later hits override earlier ones.
module sb_fwd_match
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  sb_entry_t             ents [DEPTH],
  input  logic [DEPTH-1:0]      valid,
  input  logic [PTR_W-1:0]      head,
  input  logic [SB_ADDR_W-1:0]  ld_addr,
  output logic                  hit,
  output logic [SB_DATA_W-1:0]  data
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && word_match(ents[idx].addr, ld_addr)) begin
        hit  = 1'b1;
        data = ents[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer in front of a single-port data memory.
// STORE_BUF_FWD_EN: forward from buffered stores; otherwise stall loads on hit.
module store_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              empty,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        ents [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] off;
  logic             hit;
  logic             ld_stall;
  logic             ld_use;
  logic             drain;
  logic             full;
  logic             accept;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head;
      valid[i] = {1'b0, off} < count;
    end
  end

`ifdef STORE_BUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;

  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .ents    (ents),
    .valid   (valid),
    .head    (head),
    .ld_addr (ld_addr),
    .hit     (hit),
    .data    (fwd_data)
  );

  assign ld_stall = 1'b0;
  assign ld_data  = (ld_valid && hit) ? fwd_data : mem_rd;
`else
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && word_match(ents[i].addr, ld_addr)) begin
        hit = 1'b1;
      end
    end
  end

  // Hit stalls the load; the port keeps draining so the hit clears.
  assign ld_stall = ld_valid && hit;
  assign ld_data  = mem_rd;
`endif

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign ld_use = ld_valid && !ld_stall;
  assign drain  = !empty && !ld_use;
  assign accept = st_valid && (!full || drain);
  assign stall  = (st_valid && full && !drain) || ld_stall;

  always_comb begin
    mem_we = 1'b0;
    mem_a  = ld_addr;
    mem_wd = '0;
    if (!reset) begin
      mem_a = '0;
    end else if (drain) begin
      mem_we = 1'b1;
      mem_a  = ents[head].addr;
      mem_wd = ents[head].data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (drain) head <= head + 1'b1;
      if (accept) tail <= tail + 1'b1;
      unique case ({accept, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      ents[tail] <= '{addr: st_addr, data: st_data};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued
// at store issue and popped as the DUT writes the memory model.
module tb_store_buffer;

  logic        clk = 0;
  logic        reset = 0;
  logic        st_valid = 0;
  logic [31:0] st_addr = 0;
  logic [31:0] st_data = 0;
  logic        ld_valid = 0;
  logic [31:0] ld_addr = 0;
  logic [31:0] ld_data;
  logic        stall;
  logic        empty;
  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [256];
  logic [63:0] exp_q [$];
  int n_cmp = 0;
  int n_bad = 0;

  store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_data  (st_data),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_data  (ld_data),
    .stall    (stall),
    .empty    (empty),
    .mem_we   (mem_we),
    .mem_a    (mem_a),
    .mem_wd   (mem_wd),
    .mem_rd   (mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_a[9:2]];

  always @(posedge clk) if (mem_we) mem[mem_a[9:2]] = mem_wd;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return 32'hD000_0000 | {24'h0, a[9:2]};
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  // Every memory write must be the oldest outstanding expected store.
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) check("spurious_we", {mem_a, mem_wd}, 64'h0);
      else check("wr_order", {mem_a, mem_wd}, exp_q.pop_front());
    end
  end

  task automatic next;
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input bit push);
    st_valid = 1; st_addr = a; st_data = d;
    if (push) exp_q.push_back({a, d});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hD000_0000 | i;
    #12;
    @(negedge clk);
    check("rst_empty", empty, 1);
    check("rst_stall", stall, 0);
    check("rst_we", mem_we, 0);
    check("rst_a", mem_a, 0);
    check("rst_wd", mem_wd, 0);
    next; reset = 1;

    // Basic drain
    store(32'h10, 32'h11, 1);
    @(negedge clk); check("bd_we0", mem_we, 0);
    next; store(32'h14, 32'h22, 1);
    @(negedge clk); check("bd_we1", mem_we, 1);
    next; store(32'h18, 32'h33, 1);
    next; st_valid = 0;
    @(negedge clk); check("bd_we3", mem_we, 1);
    check("bd_empty3", empty, 0);
    next;
    @(negedge clk); check("bd_empty4", empty, 1);
    check("bd_we4", mem_we, 0);

    // Full stall, then full-and-drain
    next; ld_valid = 1; ld_addr = 32'h100;
    for (int i = 0; i < 4; i++) begin
      store(32'h200 + 4 * i, 32'hA0 + i, 1);
      @(negedge clk);
      check("fs_nostall", stall, 0);
      check("fs_ld", ld_data, init_word(32'h100));
      next;
    end
    store(32'h210, 32'hA4, 0);
    @(negedge clk); check("fs_stall", stall, 1);
    check("fs_nodrain", mem_we, 0);
    next; ld_valid = 0; exp_q.push_back({32'h210, 32'hA4});
    @(negedge clk); check("fd_stall", stall, 0);
    check("fd_we", mem_we, 1);
    next; st_valid = 0;
    next; next; next;
    @(negedge clk); check("fd_cnt4", empty, 0);
    next;
    @(negedge clk); check("fd_empty", empty, 1);

`ifdef STORE_BUF_FWD_EN
    // Forwarding from the youngest matching entry
    next; ld_valid = 1; ld_addr = 32'h100;
    store(32'h40, 32'hAAAA, 1);
    next; store(32'h40, 32'hBBBB, 1);
    next; st_valid = 0; ld_addr = 32'h42;
    @(negedge clk); check("fw_hit", ld_data, 32'hBBBB);
    check("fw_stall", stall, 0);
    next; ld_addr = 32'h44;
    @(negedge clk); check("fw_miss", ld_data, init_word(32'h44));
    next; ld_valid = 0;
    next; next;
    @(negedge clk); check("fw_empty", empty, 1);
`else
    // Load hitting the second of two entries stalls until both drain
    next; ld_valid = 1; ld_addr = 32'h100;
    store(32'h80, 32'h1234, 1);
    next; store(32'h84, 32'h5678, 1);
    next; st_valid = 0; ld_addr = 32'h84;
    @(negedge clk); check("nf_stall0", stall, 1);
    next;
    @(negedge clk); check("nf_stall1", stall, 1);
    next;
    @(negedge clk); check("nf_stall2", stall, 0);
    check("nf_ld", ld_data, 32'h5678);
    next; ld_valid = 0;
`endif

    // Reset mid-operation drops buffered stores
    next; ld_valid = 1; ld_addr = 32'h100;
    store(32'h300, 32'h1, 0);
    next; store(32'h304, 32'h2, 0);
    next; store(32'h308, 32'h3, 0);
    next; st_valid = 0; reset = 0;
    #1;
    check("mr_empty", empty, 1);
    check("mr_stall", stall, 0);
    check("mr_we", mem_we, 0);
    next; reset = 1; ld_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("mr_nowe", mem_we, 0);
      next;
    end

    check("q_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
